dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory access controller between the MEM pipeline stage, a secondary DMA requester, and the single-port data memory. Arbitrates the two requesters, sequences each access over a variable-latency ready handshake, and generates byte enables and write-lane replication. Stalls the pipeline until the access completes, and sign/zero-extends load data per RV32I funct3. Sits beside the MEM pipeline register and replaces the direct address/write-data wiring to data memory.

## Interface
- STARVE_MAX, 4: consecutive CPU wins allowed while DMA waits before DMA is forced (1..15).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_rd / cpu_wr  in  1 / 1  load / store request from MEM stage; held stable while cpu_stall=1.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data (rs2).
- cpu_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_stall  out  1  freeze pipeline.
- cpu_rdata  out  32  extended load data; valid in the completion cycle.
- cpu_fault  out  1  one-cycle pulse on a misaligned access or illegal cpu_size.
- dma_req, dma_we  in  1, 1  DMA request / write select; held until dma_done.
- dma_addr, dma_wdata  in  32, 32  word-aligned address (bits [1:0] ignored), write data.
- dma_gnt  out  1  DMA owns the memory.
- dma_done  out  1  one-cycle completion pulse.
- dma_rdata  out  32  raw read word, valid with dma_done.
- mem_req, mem_we  out  1, 1  memory strobe / write.
- mem_addr  out  32  word address ({addr[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_ready  in  1  access complete (write accepted or mem_rdata valid).
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, CPU_BUSY, DMA_BUSY. The state register, latched address/size/wdata/we, and starve counter are reset by reset.
- IDLE arbitration: CPU wins over DMA unless starve_cnt==STARVE_MAX; then DMA wins and starve_cnt clears.
  - starve_cnt increments on each CPU win while dma_req=1 and saturates at STARVE_MAX.
  - starve_cnt clears on any DMA grant.
- CPU request checks:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal size: cpu_size 011, 110, or 111 for loads; anything other than 000/001/010 for stores.
  - Either case makes the request ineligible: cpu_fault=1 for that cycle, no stall, no memory access, state stays IDLE.
- On a win, latch the requester's fields and go to the matching BUSY state. mem_req=1 for the whole BUSY state, with the latched fields driven.
- Byte enables: B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111; DMA → 4'b1111 (both reads and writes).
- Write lanes:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- Load extraction: select the byte or half at addr[1:0] from mem_rdata. Sign-extend for 000/001, zero-extend for 100/101.
- BUSY with mem_ready=1 is the completion cycle and returns to IDLE.
  - CPU: cpu_stall=0; cpu_rdata valid.
  - DMA: dma_done=1, dma_rdata=mem_rdata.
- cpu_stall (combinational) = (cpu_rd|cpu_wr) & eligible & !(state==CPU_BUSY & mem_ready).
- dma_gnt = (state==DMA_BUSY).
- cpu_rd and cpu_wr both high: treated as a store.

## Timing
- Reset values: state IDLE, mem_req=0, mem_we=0, mem_be=0, dma_gnt=0, dma_done=0, cpu_fault=0, cpu_rdata=0, dma_rdata=0, starve_cnt=0.
  - cpu_stall is 0 while reset is asserted.
- Reset asserted mid-access: mem_req drops immediately (asynchronous), the access is abandoned, and no done or completion is signalled.
- Minimum access is 2 cycles:
  - Cycle 0: request seen in IDLE, stall=1.
  - Cycle 1: mem_req=1; if mem_ready=1, stall=0 and data valid.
  - Cycle 2: IDLE, next request arbitrated.
- Each extra mem_ready-low cycle adds one stall cycle. There is no timeout.
- mem_ready is ignored in IDLE.
- A DMA access in progress stalls a newly arriving CPU request until DMA completes plus one IDLE arbitration cycle.

## Configuration
- DMEM_DMA_PORT_EN defined: behaviour as above.
- DMEM_DMA_PORT_EN undefined:
  - DMA_BUSY and the starve counter are removed; dma_* inputs are ignored.
  - dma_gnt, dma_done, and dma_rdata are tied to 0.
  - The CPU always wins.

## Test plan
- LB, addr 0x103, mem_rdata 0x80xxxxxx, mem_ready in cycle 1 → mem_be=1000, cpu_rdata=0xFFFFFF80, stall high for exactly 1 cycle.
- SH, addr 0x202, wdata 0x0000BEEF, mem_ready delayed 3 cycles → mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1, stall high 4 cycles.
- LW, addr 0x101 → cpu_fault pulse, cpu_stall=0, mem_req never asserted.
- dma_req held high with continuous CPU loads, STARVE_MAX=4, mem_ready always 1 → DMA granted after the 4th CPU access completes; dma_done pulses; CPU stalls 2 extra cycles.
- Reset asserted during CPU_BUSY → mem_req=0 in the same cycle; after release, state is IDLE and the pending load is re-issued from cycle 0.
- DMEM_DMA_PORT_EN undefined, dma_req=1 constantly → dma_gnt stays 0 and CPU accesses are unaffected.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller for the MEM stage.
// Arbitrates the CPU and a secondary DMA requester onto the single-port data
// memory. Generates byte enables and write-lane replication, and sign/zero
// extends load data.
// Optional feature macro: DMEM_DMA_PORT_EN adds the DMA requester port. When
// the macro is undefined, dma_* inputs are ignored and dma_* outputs are tied low.
module dmem_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_size,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_fault,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

`ifdef DMEM_DMA_PORT_EN
  localparam int unsigned SW = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CPU_BUSY = 2'd1, DMA_BUSY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CPU_BUSY = 2'd1} state_e;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;

  logic            cpu_req_c;
  logic            size_ok_c;
  logic            misaligned_c;
  logic            cpu_ok_c;
  logic            cpu_done_c;
  logic [DW-1:0]   lane_rd_c;

`ifdef DMEM_DMA_PORT_EN
  logic [SW-1:0]   starve_q, starve_d;
  logic            starve_hit_c;
`else
  localparam int unsigned UNUSED_STARVE = STARVE_MAX;
  logic unused_dma;
  assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_wdata};
`endif

  // Qualify the CPU request: legal funct3 for the direction and natural alignment.
  always_comb begin
    cpu_req_c = cpu_rd | cpu_wr;
    if (cpu_wr) begin
      size_ok_c = (cpu_size == 3'b000) || (cpu_size == 3'b001) || (cpu_size == 3'b010);
    end else begin
      size_ok_c = (cpu_size == 3'b000) || (cpu_size == 3'b001) || (cpu_size == 3'b010) ||
                  (cpu_size == 3'b100) || (cpu_size == 3'b101);
    end
    misaligned_c = (((cpu_size == 3'b001) || (cpu_size == 3'b101)) && cpu_addr[0]) ||
                   ((cpu_size == 3'b010) && (cpu_addr[1:0] != 2'b00));
    cpu_ok_c   = cpu_req_c && size_ok_c && !misaligned_c;
    cpu_done_c = (state_q == CPU_BUSY) && mem_ready;
  end

`ifdef DMEM_DMA_PORT_EN
  assign starve_hit_c = (starve_q == SW'(STARVE_MAX));
`endif

  // Next-state: arbitration in IDLE, completion on mem_ready in either BUSY state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    we_d    = we_q;
`ifdef DMEM_DMA_PORT_EN
    starve_d = starve_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef DMEM_DMA_PORT_EN
        if (dma_req && (!cpu_ok_c || starve_hit_c)) begin
          state_d  = DMA_BUSY;
          addr_d   = {dma_addr[AW-1:2], 2'b00};
          size_d   = 3'b010;
          wdata_d  = dma_wdata;
          we_d     = dma_we;
          starve_d = '0;
        end else
`endif
        if (cpu_ok_c) begin
          state_d = CPU_BUSY;
          addr_d  = cpu_addr;
          size_d  = cpu_size;
          wdata_d = cpu_wdata;
          we_d    = cpu_wr;
`ifdef DMEM_DMA_PORT_EN
          if (dma_req && !starve_hit_c) begin
            starve_d = starve_q + SW'(1);
          end
`endif
        end
      end
      CPU_BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
`ifdef DMEM_DMA_PORT_EN
      DMA_BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and latched access fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

`ifdef DMEM_DMA_PORT_EN
  // Starvation counter: consecutive CPU wins while DMA waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign lane_rd_c = mem_rdata >> {addr_q[1:0], 3'b000};

  // Memory strobes, lanes, load extraction and requester handshakes.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    cpu_stall = 1'b0;
    cpu_fault = 1'b0;
    cpu_rdata = '0;
    dma_gnt   = 1'b0;
    dma_done  = 1'b0;
    dma_rdata = '0;

    if (state_q != IDLE) begin
      mem_req  = 1'b1;
      mem_we   = we_q;
      mem_addr = {addr_q[AW-1:2], 2'b00};
      case (size_q[1:0])
        2'b00: begin
          mem_be    = BEW'(4'b0001 << addr_q[1:0]);
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = BEW'(4'b0011 << addr_q[1:0]);
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end

    // Reset holds the pipeline free even though the request lines are still up.
    cpu_stall = !reset && cpu_ok_c && !cpu_done_c;
    cpu_fault = !reset && cpu_req_c && !cpu_ok_c;

    if (cpu_done_c) begin
      case (size_q)
        3'b000:  cpu_rdata = {{24{lane_rd_c[7]}}, lane_rd_c[7:0]};
        3'b001:  cpu_rdata = {{16{lane_rd_c[15]}}, lane_rd_c[15:0]};
        3'b100:  cpu_rdata = {24'd0, lane_rd_c[7:0]};
        3'b101:  cpu_rdata = {16'd0, lane_rd_c[15:0]};
        default: cpu_rdata = lane_rd_c;
      endcase
    end

`ifdef DMEM_DMA_PORT_EN
    dma_gnt  = (state_q == DMA_BUSY);
    dma_done = dma_gnt && mem_ready;
    if (dma_done) begin
      dma_rdata = mem_rdata;
    end
`endif
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized self-checking bench for dmem_ctrl against a
// transaction-level memory model.
module tb_dmem_ctrl;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned MEM_WORDS  = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_size;
  logic        cpu_stall, cpu_fault;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [31:0] dma_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_q  [MEM_WORDS];  // memory seen by the DUT
  logic [31:0] shadow [MEM_WORDS];  // expected memory image

  int forced_delay = -1;
  int wait_max     = 3;
  bit in_acc;
  int acc_cyc, acc_delay;
  int waits_total;

  bit          dma_on, dma_const, dma_pend, dma_we_m;
  logic [31:0] dma_addr_m, dma_wdata_m;
  int          dma_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_fault(input bit st, input logic [2:0] sz, input logic [1:0] off);
    bit legal, mis;
    if (st) legal = (sz <= 3'd2);
    else    legal = (sz <= 3'd2) || (sz == 3'd4) || (sz == 3'd5);
    mis = ((sz[1:0] == 2'd1) && off[0]) || ((sz[1:0] == 2'd2) && (off != 2'd0));
    return !legal || mis;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] sz,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sz)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Drive memory responder and DMA requester for the cycle just begun.
  task automatic drive_cycle();
    if (!dma_pend && dma_on && ($urandom_range(0, 3) == 0)) begin
      dma_pend    = 1'b1;
      dma_we_m    = 1'($urandom_range(0, 1));
      dma_addr_m  = $urandom;
      dma_wdata_m = $urandom;
    end
    dma_req   = dma_pend | dma_const;
    dma_we    = dma_pend ? dma_we_m : 1'($urandom);
    dma_addr  = dma_pend ? dma_addr_m : $urandom;
    dma_wdata = dma_pend ? dma_wdata_m : $urandom;
    if (mem_req && !in_acc) begin
      in_acc    = 1'b1;
      acc_cyc   = 0;
      acc_delay = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, wait_max));
    end
    mem_ready = in_acc ? (acc_cyc == acc_delay) : 1'($urandom);
    mem_rdata = mem_req ? mem_q[mem_addr[9:2]] : $urandom;
  endtask

  // Handle DMA completion, commit memory writes, then advance one clock.
  task automatic finish_cycle();
    logic [7:0] didx, widx;
    if (dma_done) begin
      didx = dma_addr_m[9:2];
      chk("dma_pending", 32'(dma_pend), 32'd1);
      chk("dma_addr", mem_addr, {dma_addr_m[31:2], 2'b00});
      chk("dma_be", 32'(mem_be), 32'hF);
      if (dma_we_m) begin
        chk("dma_wdata", mem_wdata, dma_wdata_m);
        shadow[didx] = dma_wdata_m;
      end else begin
        chk("dma_rdata", dma_rdata, shadow[didx]);
      end
      dma_pend = 1'b0;
      dma_cnt++;
    end
`ifndef DMEM_DMA_PORT_EN
    chk("dma_tied_off", {29'd0, dma_gnt, dma_done, |dma_rdata}, 32'd0);
`endif
    if (mem_req && mem_ready && mem_we) begin
      widx = mem_addr[9:2];
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[widx][8*i +: 8] = mem_wdata[8*i +: 8];
      end
    end
    if (in_acc) begin
      if (mem_ready) in_acc = 1'b0;
      else begin
        acc_cyc++;
        waits_total++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input bit st, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit chk_stall, output int stalls);
    bit          flt, done;
    int          w0, o, nb;
    logic [7:0]  idx;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    o   = int'(a[1:0]);
    idx = a[9:2];
    flt = is_fault(st, sz, a[1:0]);
    nb  = 1 << sz[1:0];
    for (int i = 0; i < 4; i++) begin
      be_e[i]        = (i >= o) && (i < o + nb);
      wd_e[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    cpu_rd    = !st || ($urandom_range(0, 3) == 0);
    cpu_wr    = st;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_size  = sz;
    w0     = waits_total;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      drive_cycle();
      #1;
      if (flt) begin
        chk("fault_pulse", 32'(cpu_fault), 32'd1);
        chk("fault_nostall", 32'(cpu_stall), 32'd0);
        chk("fault_nomem", 32'(mem_req && !dma_gnt), 32'd0);
        done = 1'b1;
      end else if (cpu_stall) begin
        stalls++;
      end else begin
        done = 1'b1;
        chk("legal_nofault", 32'(cpu_fault), 32'd0);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_be", 32'(mem_be), 32'(be_e));
        chk("mem_we", 32'(mem_we), 32'(st));
        if (st) begin
          chk("mem_wdata", mem_wdata, wd_e);
          for (int i = 0; i < 4; i++) begin
            if (be_e[i]) shadow[idx][8*i +: 8] = wd[8*(i - o) +: 8];
          end
        end else begin
          chk("cpu_rdata", cpu_rdata, load_val(shadow[idx], sz, a[1:0]));
        end
        if (chk_stall) chk("stall_cycles", 32'(stalls), 32'(1 + waits_total - w0));
      end
      finish_cycle();
    end
    chk("cpu_timeout", 32'(done), 32'd1);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic idle_cycle();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    drive_cycle();
    #1;
    chk("idle_quiet", {30'd0, cpu_stall, cpu_fault}, 32'd0);
    finish_cycle();
  endtask

  initial begin
    int          s, c0, bad_words;
    bit          st;
    logic [2:0]  sz;
    logic [31:0] a;
    bit          sc;

    reset = 1'b1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h100; cpu_wdata = '0; cpu_size = 3'b010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_q[i]  = $urandom;
      shadow[i] = mem_q[i];
    end
    dma_on = 0; dma_const = 0; dma_pend = 0; in_acc = 0; waits_total = 0; dma_cnt = 0;
    dma_we_m = 0; dma_addr_m = '0; dma_wdata_m = '0; acc_cyc = 0; acc_delay = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_dma", {30'd0, dma_gnt, dma_done}, 32'd0);
    chk("rst_fault", 32'(cpu_fault), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    reset = 1'b0;
    cpu_rd = 1'b0;
    dma_req = 1'b0;

    // LB from the top byte lane with a negative value.
    forced_delay = 0;
    mem_q[8'h40] = 32'h80AB_CD12;
    shadow[8'h40] = 32'h80AB_CD12;
    cpu_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b1, s);
    chk("lb_stall", 32'(s), 32'd1);

    // SH to the upper half with a three-cycle memory wait, then read it back.
    forced_delay = 3;
    cpu_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 1'b1, s);
    chk("sh_stall", 32'(s), 32'd4);
    forced_delay = 0;
    cpu_op(1'b0, 3'b101, 32'h0000_0202, 32'd0, 1'b1, s);
    cpu_op(1'b0, 3'b001, 32'h0000_0202, 32'd0, 1'b1, s);
    cpu_op(1'b0, 3'b100, 32'h0000_0201, 32'd0, 1'b1, s);

    // Misaligned and illegal-size requests.
    cpu_op(1'b0, 3'b010, 32'h0000_0101, 32'd0, 1'b1, s);
    cpu_op(1'b0, 3'b001, 32'h0000_0103, 32'd0, 1'b1, s);
    cpu_op(1'b1, 3'b100, 32'h0000_0100, 32'd0, 1'b1, s);
    cpu_op(1'b0, 3'b011, 32'h0000_0100, 32'd0, 1'b1, s);
    cpu_op(1'b1, 3'b101, 32'h0000_0100, 32'd0, 1'b1, s);

    // Reset during CPU_BUSY abandons the access; the load is then re-issued.
    forced_delay = 10;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0040; cpu_size = 3'b010;
    drive_cycle();
    #1;
    chk("rstmid_idle_stall", 32'(cpu_stall), 32'd1);
    finish_cycle();
    drive_cycle();
    #1;
    chk("rstmid_busy_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_req_drop", 32'(mem_req), 32'd0);
    chk("rstmid_stall_drop", 32'(cpu_stall), 32'd0);
    chk("rstmid_no_done", {30'd0, dma_done, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_acc = 1'b0;
    forced_delay = 0;
    cpu_op(1'b0, 3'b010, 32'h0000_0040, 32'd0, 1'b1, s);
    chk("reissue_stall", 32'(s), 32'd1);

`ifdef DMEM_DMA_PORT_EN
    // DMA waits behind STARVE_MAX CPU wins, then is forced in.
    dma_pend = 1'b1; dma_we_m = 1'b0; dma_addr_m = 32'h0000_0083; dma_wdata_m = '0;
    c0 = dma_cnt;
    for (int k = 0; k < 5; k++) begin
      cpu_op(1'b0, 3'b010, 32'(16 * k), 32'd0, 1'b0, s);
      chk("starve_stall", 32'(s), (k < 4) ? 32'd1 : 32'd3);
      chk("starve_done_cnt", 32'(dma_cnt - c0), (k < 4) ? 32'd0 : 32'd1);
    end
`else
    // Without the DMA port, a constant dma_req must not disturb the CPU.
    dma_const = 1'b1;
    c0 = dma_cnt;
    for (int k = 0; k < 5; k++) begin
      cpu_op(1'b0, 3'b010, 32'(16 * k), 32'd0, 1'b1, s);
      chk("nodma_stall", 32'(s), 32'd1);
    end
    chk("nodma_done_cnt", 32'(dma_cnt - c0), 32'd0);
`endif

    // Randomized mixed traffic.
    forced_delay = -1;
`ifdef DMEM_DMA_PORT_EN
    dma_on = 1'b1;
    sc = 1'b0;
`else
    sc = 1'b1;
`endif
    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sz = 3'($urandom);
      else if (st) sz = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: sz = 3'd0;
          1: sz = 3'd1;
          2: sz = 3'd2;
          3: sz = 3'd4;
          default: sz = 3'd5;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz[1:0] == 2'd1) a[0] = 1'b0;
        if (sz[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      cpu_op(st, sz, a, $urandom, sc, s);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    dma_on = 1'b0;
    for (int k = 0; k < 200 && dma_pend; k++) idle_cycle();
    chk("dma_drain", 32'(dma_pend), 32'd0);

    bad_words = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if (mem_q[i] !== shadow[i]) bad_words++;
    end
    chk("mem_image", 32'(bad_words), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
